// File: rtl/mv_store_ram.sv
// mv_store_ram: motion-vector store with one write port and two independent
// registered read ports. Each entry is a packed MV {y, x}, two's complement,
// x in the low half. After reset an INIT sweep zero-fills every entry before
// normal operation starts; writes are saturated to +/-MV_LIMIT per component.
// Optional build macro: MV_TRACE_EN (simulation-only write trace to the
// console).
module mv_store_ram #(
  parameter int DEPTH    = 8040,
  parameter int AW       = 14,
  parameter int CW       = 7,
  parameter int MV_LIMIT = 36,
  parameter int WR_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*CW-1:0] wr_vec,
  output logic            wr_drop,
  input  logic            rd_en_a,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [2*CW-1:0] rd_vec_a,
  output logic            rd_valid_a,
  input  logic            rd_en_b,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [2*CW-1:0] rd_vec_b,
  output logic            rd_valid_b,
  output logic            init_busy
);

  // Internal index width: just enough bits to address DEPTH entries.
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]            DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [MW-1:0]          LAST    = MW'(DEPTH - 1);
  localparam logic signed [CW-1:0]   LIM_P   = CW'(MV_LIMIT);
  localparam logic signed [CW-1:0]   LIM_N   = -LIM_P;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  // Clip one MV component into [-MV_LIMIT, +MV_LIMIT].
  function automatic logic signed [CW-1:0] sat_c(input logic signed [CW-1:0] v);
    if (v > LIM_P) return LIM_P;
    if (v < LIM_N) return LIM_N;
    return v;
  endfunction

  // Address lies inside the populated part of the address space.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  logic [2*CW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic          run;

  logic signed [CW-1:0] wr_sat_x_p0, wr_sat_y_p0;
  logic [2*CW-1:0]      wr_sat_p0;
  logic                 wr_ok_p0, wr_drop_p0;
  logic                 mem_we;
  logic [MW-1:0]        mem_waddr;
  logic [2*CW-1:0]      mem_wdata;

  logic                 rd_ok_a_p0, rd_ok_b_p0;
  logic                 rd_in_a_p0, rd_in_b_p0;
  logic                 rd_hit_a_p0, rd_hit_b_p0;

  logic                 vld_a_p1, vld_b_p1, wr_drop_p1;
  logic [2*CW-1:0]      vec_a_p1, vec_b_p1;

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);

  // FSM state and zero-fill counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every address once, leave INIT on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + MW'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // ---- stage p0: request decode, saturation and memory port selection ----
  always_comb begin
    wr_sat_x_p0 = sat_c($signed(wr_vec[CW-1:0]));
    wr_sat_y_p0 = sat_c($signed(wr_vec[2*CW-1:CW]));
    wr_sat_p0   = {wr_sat_y_p0, wr_sat_x_p0};
    wr_ok_p0    = rst_n && run && we && in_range(wr_addr);
    wr_drop_p0  = we && (!run || !in_range(wr_addr));

    // The INIT sweep owns the write port; accepted writes only happen in RUN.
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
    end else if (wr_ok_p0) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr[MW-1:0];
      mem_wdata = wr_sat_p0;
    end

    rd_ok_a_p0  = run && rd_en_a;
    rd_ok_b_p0  = run && rd_en_b;
    rd_in_a_p0  = in_range(rd_addr_a);
    rd_in_b_p0  = in_range(rd_addr_b);
    // Same-cycle collision bypass only when new data must win.
    rd_hit_a_p0 = (WR_FIRST != 0) && wr_ok_p0 && (rd_addr_a == wr_addr);
    rd_hit_b_p0 = (WR_FIRST != 0) && wr_ok_p0 && (rd_addr_b == wr_addr);
  end

  // Storage array write; contents are cleared by the INIT sweep, never by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---- stage p1: registered read data, valids and drop pulse ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_a_p1 <= 1'b0;
      vec_a_p1 <= '0;
    end else begin
      vld_a_p1 <= rd_ok_a_p0;
      if (rd_ok_a_p0) begin
        if (!rd_in_a_p0)      vec_a_p1 <= '0;
        else if (rd_hit_a_p0) vec_a_p1 <= wr_sat_p0;
        else                  vec_a_p1 <= mem[rd_addr_a[MW-1:0]];
      end
    end
  end

  // Port B output register, identical behaviour to port A.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_b_p1 <= 1'b0;
      vec_b_p1 <= '0;
    end else begin
      vld_b_p1 <= rd_ok_b_p0;
      if (rd_ok_b_p0) begin
        if (!rd_in_b_p0)      vec_b_p1 <= '0;
        else if (rd_hit_b_p0) vec_b_p1 <= wr_sat_p0;
        else                  vec_b_p1 <= mem[rd_addr_b[MW-1:0]];
      end
    end
  end

  // One-cycle pulse for a write that was refused.
  always_ff @(posedge clk) begin
    if (!rst_n) wr_drop_p1 <= 1'b0;
    else        wr_drop_p1 <= wr_drop_p0;
  end

  assign rd_vec_a   = vec_a_p1;
  assign rd_valid_a = vld_a_p1;
  assign rd_vec_b   = vec_b_p1;
  assign rd_valid_b = vld_b_p1;
  assign wr_drop    = wr_drop_p1;

`ifdef MV_TRACE_EN
  // Log every accepted write (saturated values) and every refused write.
  always @(posedge clk) begin
    if (rst_n) begin
      if (wr_ok_p0) begin
        $display("( %0d, %0d)", wr_sat_x_p0, wr_sat_y_p0);
      end else if (wr_drop_p0) begin
        $display("DROP addr=%0d", wr_addr);
      end
    end
  end
`endif

endmodule
